// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//
// Purpose:
//   Front end for the game's push buttons. Each raw, asynchronous, active-high
//   button input is passed through a two-flop synchroniser and then debounced
//   by a small per-channel state machine. The block produces a clean
//   debounced level plus one-cycle press and release pulses. The game state
//   machine downstream can therefore treat btn_press as an edge event
//   directly.
//
// Optional feature:
//   BUTTON_COND_HOLD_EN  When this macro is defined, a per-channel hold
//                        counter is built. btn_hold gives one pulse per press
//                        once the button has been held for HOLD_CYCLES
//                        cycles. When the macro is undefined, btn_hold is
//                        tied to 0.
//
// Ports:
//   clk          in   1         system clock
//   reset        in   1         synchronous, active-high reset
//   btn_raw      in   NUM_BTNS  raw button inputs (asynchronous, active-high)
//   btn_level    out  NUM_BTNS  debounced button state
//   btn_press    out  NUM_BTNS  1-cycle pulse when btn_level rises
//   btn_release  out  NUM_BTNS  1-cycle pulse when btn_level falls
//   btn_hold     out  NUM_BTNS  1-cycle long-press pulse
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int NUM_BTNS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int HOLD_W          = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_hold
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Both counters must be able to reach their thresholds without wrapping.
    if ((DEBOUNCE_CYCLES < 1) ||
        (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) ||
        (HOLD_CYCLES < 1) ||
        (longint'(HOLD_CYCLES) >= (longint'(1) << HOLD_W))) begin : g_bad_param
        $error("button_conditioner: counter width too small for threshold");
    end

    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;

    // Two-flop synchroniser for every channel. The debounce logic only ever
    // looks at sync2.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;

        // Debounce rule: a change is accepted only after sync2 has held the
        // new value on DEBOUNCE_CYCLES+1 consecutive samples. A single sample
        // of the old value drops the channel back to its stable state, and no
        // pulse is produced in that case.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync2[i]) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DEB_MAX) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2[i]) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2[i]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == DEB_MAX) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end
            endcase
        end

        // State and output registers. A reset silently drops a held button:
        // level returns to 0 and no release pulse is produced.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

`ifdef BUTTON_COND_HOLD_EN
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

        logic [HOLD_W-1:0] hold_cnt_q;
        logic              hold_q;

        // Long-press detector. The counter runs while the debounced level is
        // high (PRESSED or RELEASE_WAIT) and saturates at HOLD_MAX, so a
        // single press gives exactly one pulse. The counter is cleared once
        // the channel is back in IDLE.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
            end else begin
                hold_q <= 1'b0;
                if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        if (hold_cnt_q == HOLD_PRE) begin
                            hold_q <= 1'b1;
                        end
                    end
                end else if (state_q == IDLE) begin
                    hold_cnt_q <= '0;
                end
            end
        end

        assign btn_hold[i] = hold_q;
`else
        assign btn_hold[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//
// Purpose:
//   Self-checking bench for button_conditioner (NUM_BTNS=2, DEBOUNCE_CYCLES=4,
//   HOLD_CYCLES=10). It runs a set of directed scenarios and then random
//   button activity with occasional resets. Every cycle, all outputs are
//   compared with a behavioural model. The model treats each button as a
//   two-sample delay followed by a run-length filter: the debounced level
//   flips once DEBOUNCE_CYCLES+1 consecutive samples disagree with it.
//   The hold expectation follows BUTTON_COND_HOLD_EN, the same macro used by
//   the design.
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int HLD = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_hold;

    button_conditioner #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .HOLD_CYCLES     (HLD),
        .HOLD_W          (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold)
    );

    always #5 clk = ~clk;

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference model state, one entry per channel.
    logic [NB-1:0] m_hist0;
    logic [NB-1:0] m_hist1;
    logic [NB-1:0] m_level;
    int            m_run   [NB];
    int            m_hcnt  [NB];
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_release;
    logic [NB-1:0] exp_hold;

    // Counts of output pulses observed, used by the directed scenarios.
    int press_cnt   [NB];
    int release_cnt [NB];
    int hold_cnt    [NB];

    // Compares one observed value with its expected value, counts the
    // comparison, and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got !== want) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Advances the model by one clock edge, using the inputs that the DUT
    // sampled on that edge.
    task automatic modelStep(input logic [NB-1:0] r, input logic rst);
        exp_press   = '0;
        exp_release = '0;
        exp_hold    = '0;
        for (int ch = 0; ch < NB; ch++) begin
            if (rst) begin
                m_hist0[ch] = 1'b0;
                m_hist1[ch] = 1'b0;
                m_level[ch] = 1'b0;
                m_run[ch]   = 0;
                m_hcnt[ch]  = 0;
            end else begin
                // The long press is measured while the accepted level is
                // high, one pulse per press.
                if (m_level[ch]) begin
                    if (m_hcnt[ch] < HLD) begin
                        m_hcnt[ch]++;
                        if (m_hcnt[ch] == HLD) exp_hold[ch] = 1'b1;
                    end
                end else begin
                    m_hcnt[ch] = 0;
                end
                // The synchronised sample is the raw value from two edges
                // earlier.
                if (m_hist1[ch] != m_level[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DEB + 1) begin
                        m_level[ch] = m_hist1[ch];
                        if (m_hist1[ch]) exp_press[ch] = 1'b1;
                        else             exp_release[ch] = 1'b1;
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                m_hist1[ch] = m_hist0[ch];
                m_hist0[ch] = r[ch];
            end
        end
`ifndef BUTTON_COND_HOLD_EN
        exp_hold = '0;
`endif
    endtask

    // Drives one cycle of inputs on the falling edge. After the next rising
    // edge it updates the model and checks every output.
    task automatic applyStimulus(input logic [NB-1:0] r, input logic rst);
        @(negedge clk);
        btn_raw = r;
        reset   = rst;
        @(posedge clk);
        #1;
        modelStep(r, rst);
        checkOutput("btn_level",   32'(btn_level),   32'(m_level));
        checkOutput("btn_press",   32'(btn_press),   32'(exp_press));
        checkOutput("btn_release", 32'(btn_release), 32'(exp_release));
        checkOutput("btn_hold",    32'(btn_hold),    32'(exp_hold));
        checkOutput("press_with_release", 32'(btn_press & btn_release), 32'd0);
        for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch]   += int'(btn_press[ch]);
            release_cnt[ch] += int'(btn_release[ch]);
            hold_cnt[ch]    += int'(btn_hold[ch]);
        end
    endtask

    task automatic clearCounts();
        for (int ch = 0; ch < NB; ch++) begin
            press_cnt[ch]   = 0;
            release_cnt[ch] = 0;
            hold_cnt[ch]    = 0;
        end
    endtask

    task automatic repeatStimulus(input logic [NB-1:0] r, input logic rst, input int n);
        for (int k = 0; k < n; k++) applyStimulus(r, rst);
    endtask

    int   seg_left [NB];
    logic [NB-1:0] seg_val;
    logic [NB-1:0] rnd_raw;
    logic rnd_rst;

    initial begin
        btn_raw = '0;
        reset   = 1'b1;
        m_hist0 = '0;
        m_hist1 = '0;
        m_level = '0;
        for (int ch = 0; ch < NB; ch++) begin
            m_run[ch]  = 0;
            m_hcnt[ch] = 0;
        end
        clearCounts();

        // Both buttons are held through reset. Each must be accepted as a
        // new press exactly once after reset is released.
        repeatStimulus(2'b11, 1'b1, 3);
        clearCounts();
        repeatStimulus(2'b11, 1'b0, 12);
        checkOutput("reset_held_press0", press_cnt[0], 1);
        checkOutput("reset_held_press1", press_cnt[1], 1);
        repeatStimulus(2'b00, 1'b0, 12);

        // Channel 0 is pressed and held.
        clearCounts();
        repeatStimulus(2'b01, 1'b0, 10);
        checkOutput("ch0_press_count", press_cnt[0], 1);

        // A short glitch on channel 1 must be rejected.
        repeatStimulus(2'b11, 1'b0, 3);
        repeatStimulus(2'b01, 1'b0, 10);
        checkOutput("ch1_glitch_press", press_cnt[1], 0);
        checkOutput("ch1_glitch_release", release_cnt[1], 0);

        // Channel 0 is released with a bounce. Exactly one release is
        // expected.
        clearCounts();
        repeatStimulus(2'b00, 1'b0, 2);
        repeatStimulus(2'b01, 1'b0, 1);
        repeatStimulus(2'b00, 1'b0, 12);
        checkOutput("ch0_bounce_release", release_cnt[0], 1);

        // A long press on channel 0 gives a single hold pulse when the
        // feature is built.
        clearCounts();
        repeatStimulus(2'b01, 1'b0, 30);
        checkOutput("ch0_long_press", press_cnt[0], 1);
`ifdef BUTTON_COND_HOLD_EN
        checkOutput("ch0_hold_pulses", hold_cnt[0], 1);
`else
        checkOutput("ch0_hold_pulses", hold_cnt[0], 0);
`endif

        // Reset is asserted while channel 0 is PRESSED. Level must drop, and
        // no release pulse may appear.
        clearCounts();
        applyStimulus(2'b00, 1'b1);
        checkOutput("reset_drops_level", 32'(btn_level), 32'd0);
        repeatStimulus(2'b00, 1'b0, 12);
        checkOutput("reset_no_release", release_cnt[0], 0);

        // Random activity: segments shorter and longer than the debounce
        // window, some of them long enough to hold, with occasional resets.
        seg_val = '0;
        for (int ch = 0; ch < NB; ch++) seg_left[ch] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (seg_left[ch] == 0) begin
                    seg_val[ch]  = ~seg_val[ch];
                    seg_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                               : int'($urandom_range(1, 7));
                end
                seg_left[ch]--;
            end
            rnd_raw = seg_val;
            rnd_rst = ($urandom_range(0, 199) == 0);
            applyStimulus(rnd_raw, rnd_rst);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
